branch_resolve_ctrl: RTL and testbench
======================================

# branch_resolve_ctrl

Sequencing controller for MEM-stage branch resolution. It consumes the EX/MEM branch/zero decision, drives the PC-select (PCSrc) and redirect target, and issues flush pulses to the younger pipeline registers. It masks branch signals from squashed slots, holds a taken redirect across a pipeline stall, and keeps saturating branch statistics. It sits between the EX/MEM register and the IF-stage PC mux.

## Interface
- `ADDR_W`, default 32: branch target width.
- `SQUASH_CYC`, default 3: cycles after a redirect during which MEM-stage branch inputs are ignored. Legal range 1..7.
- `CNT_W`, default 16: statistics counter width.

Ports (the clock is `clk` and the reset is `rst`; one clock domain; `rst` is synchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `mem_valid`  in  1  EX/MEM holds a real instruction.
- `mem_branch`  in  1  Branch control bit from EX/MEM.
- `mem_zero`  in  1  ALU Zero from EX/MEM.
- `mem_target`  in  ADDR_W  branch target from EX/MEM.
- `stall_in`  in  1  pipeline frozen this cycle; no PC update and no flush are taken.
- `pcsrc`  out  1  PC mux select; 1 selects `pc_target`.
- `pc_target`  out  ADDR_W  redirect address.
- `flush_ifid`, `flush_idex`, `flush_exmem`  out  1 each  clear the named pipeline register at the next edge.
- `redirect_pending`  out  1  a taken branch is being held by a stall.
- `branch_count`  out  CNT_W  branches resolved.
- `taken_count`  out  CNT_W  branches taken.

## Operation
- Taken condition: `take = mem_valid & mem_branch & mem_zero`. Resolved condition: `mem_valid & mem_branch`.
- FSM states are IDLE, HOLD and SQUASH.
- **IDLE**
  - `take & !stall_in`: `pcsrc=1`, `pc_target=mem_target`, and all three flushes assert, combinationally in the same cycle. Load `sq_cnt=SQUASH_CYC-1`, then go to SQUASH (or to IDLE if SQUASH_CYC=1).
  - `take & stall_in`: latch `mem_target` into `hold_tgt`, assert `redirect_pending`, and go to HOLD. Outputs `pcsrc` and the flushes stay 0.
  - Not taken: all outputs are 0.
- **HOLD**
  - `redirect_pending=1` and `pc_target=hold_tgt`. All `mem_*` inputs are ignored.
  - First cycle with `!stall_in`: `pcsrc=1` and all flushes assert. Load `sq_cnt`, then go to SQUASH (or IDLE), as for IDLE.
- **SQUASH**
  - `mem_branch` and `mem_zero` are ignored and not counted. This prevents a squashed younger branch from redirecting.
  - `sq_cnt` decrements only on `!stall_in`. Exit to IDLE on a non-stalled cycle with `sq_cnt==0`.
  - `pcsrc` and the flushes are 0.
- **Counters**
  - `branch_count` increments when the resolved condition holds and the FSM is in IDLE. It counts exactly once per branch, including a stalled one at its capture cycle.
  - `taken_count` increments under the same rule when `take` is also true.
  - Both counters saturate at all-ones; there is no wrap.
- `pc_target` equals `mem_target` whenever the FSM is not in HOLD.

## Timing
- Redirect latency is 0 cycles from `take` in IDLE with no stall. `pcsrc` and the flushes are valid in the same cycle, and the PC loads the target at the next edge.
- Stalled redirect: `pcsrc` asserts in the first cycle `stall_in` falls, using `hold_tgt` even if the EX/MEM contents have changed.
- `pcsrc` and the flushes are one-cycle pulses per taken branch. They never assert while `stall_in=1`.
- **Reset values**
  - State IDLE; `sq_cnt=0` and `hold_tgt=0`.
  - `pcsrc=0`, all flushes 0, `redirect_pending=0`, and both counts 0.
  - `pc_target=mem_target` (pass-through).
- Reset in HOLD or SQUASH aborts the pending redirect. No `pcsrc` is issued afterwards.
- A `take` on the cycle SQUASH exits is ignored. IDLE is evaluated starting the following cycle.
- Counter increment and saturation both take effect at the clock edge.

## Structure
- `branch_ctrl_defs.vh` (shared include) holds the state encoding localparams (IDLE=2'd0, HOLD=2'd1, SQUASH=2'd2) and the default `SQUASH_CYC`. The hazard unit includes it as well.
- One sub-module, `sat_counter` (params `W`; ports `clk`, `rst`, `inc`, `q`), is instantiated twice for the statistics counters.
- The FSM, `sq_cnt` and `hold_tgt` live in `branch_resolve_ctrl`.

## Test plan
- **Reset:** `rst=1` for 2 cycles, with `mem_branch=1`, `mem_zero=1` and `mem_valid=1` driven → `pcsrc`, the flushes and both counts stay 0 throughout reset.
- **Taken/not-taken:**
  - (`valid`=1, `branch`=1, `zero`=0) → no `pcsrc`; `branch_count=1`, `taken_count=0`.
  - Next cycle (`valid`=1, `branch`=1, `zero`=1, `target`=0x40) → `pcsrc=1`, `pc_target=0x40` and 3 flushes in that cycle; counts become 2 and 1.
- **Squash masking:** taken branch, then `take` held high for 3 more cycles (SQUASH_CYC=3) → exactly one `pcsrc` pulse and `taken_count=1`. A `take` on cycle 4 gives a second pulse.
- **Stall hold:**
  - `take` with `target=0x80` and `stall_in=1` for 4 cycles while `mem_target` changes to 0x99 → `redirect_pending=1` for 4 cycles.
  - Then `pcsrc=1` with `pc_target=0x80` in the first unstalled cycle; `branch_count` incremented once.
- **Reset mid-HOLD:** `rst` asserted in the 2nd HOLD cycle, then released with `stall_in=0` and `mem_branch=0` → no `pcsrc` pulse ever appears.
- **Saturation:** with `CNT_W=3`, 9 consecutive taken branches spaced beyond the squash window → `taken_count` sticks at 7.

Source files
------------

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared definitions for the MEM-stage branch resolution controller.
// Contents: FSM state encoding, default squash window, squash counter width.
package branch_resolve_ctrl_pkg;

    // State encoding is shared with the hazard unit; keep the values stable.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    localparam int unsigned SQUASH_CYC_DEFAULT = 3;

    // Wide enough for the largest legal squash window (7).
    localparam int unsigned SQ_CNT_W = 3;

endpackage

// File: rtl/branch_resolve_ctrl_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones.
// Ports:
//   clk  in  1  clock
//   rst  in  1  synchronous active-high reset (clears q)
//   inc  in  1  count enable, applied at the clock edge
//   q    out W  current count
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Increment unless already saturated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + W'(1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: MEM-stage branch resolution sequencer.
// Drives the IF-stage PC mux select and redirect target, pulses flushes to
// the younger pipeline registers, holds a taken redirect across a stall,
// masks branches from squashed slots and keeps saturating statistics.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   mem_valid/branch/zero/target     EX/MEM branch decision inputs
//   stall_in                         pipeline frozen this cycle
//   pcsrc, pc_target                 PC mux select and redirect address
//   flush_ifid/idex/exmem            clear younger pipeline registers
//   redirect_pending                 taken branch held by a stall
//   branch_count, taken_count        saturating statistics
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SQUASH_CYC = SQUASH_CYC_DEFAULT,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  logic              mem_branch,
    input  logic              mem_zero,
    input  logic [ADDR_W-1:0] mem_target,
    input  logic              stall_in,
    output logic              pcsrc,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush_ifid,
    output logic              flush_idex,
    output logic              flush_exmem,
    output logic              redirect_pending,
    output logic [CNT_W-1:0]  branch_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam logic [SQ_CNT_W-1:0] SQ_LOAD = SQ_CNT_W'(SQUASH_CYC - 1);
    // A one-cycle window is just the redirect cycle itself.
    localparam state_t ST_AFTER_REDIRECT = (SQUASH_CYC == 1) ? ST_IDLE : ST_SQUASH;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SQ_CNT_W-1:0]   r_sq_cnt;
    logic [SQ_CNT_W-1:0]   w_sq_nxt;
    logic [ADDR_W-1:0]     r_hold_tgt;
    logic [ADDR_W-1:0]     w_hold_nxt;

    logic w_take;
    logic w_resolved;
    logic w_redirect;
    logic w_pending;
    logic w_sel_hold;
    logic w_cnt_branch;
    logic w_cnt_taken;

    assign w_take     = mem_valid & mem_branch & mem_zero;
    assign w_resolved = mem_valid & mem_branch;

    // State, squash counter and held target registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_sq_cnt   <= '0;
            r_hold_tgt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sq_cnt   <= w_sq_nxt;
            r_hold_tgt <= w_hold_nxt;
        end
    end

    // Next-state and redirect decode.
    always_comb begin
        w_state_nxt = r_state;
        w_sq_nxt    = r_sq_cnt;
        w_hold_nxt  = r_hold_tgt;
        w_redirect  = 1'b0;
        w_pending   = 1'b0;
        w_sel_hold  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    if (!stall_in) begin
                        w_redirect  = 1'b1;
                        w_sq_nxt    = SQ_LOAD;
                        w_state_nxt = ST_AFTER_REDIRECT;
                    end else begin
                        w_hold_nxt  = mem_target;
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // EX/MEM may have moved on; only the captured target matters.
                w_pending  = 1'b1;
                w_sel_hold = 1'b1;
                if (!stall_in) begin
                    w_redirect  = 1'b1;
                    w_sq_nxt    = SQ_LOAD;
                    w_state_nxt = ST_AFTER_REDIRECT;
                end
            end
            ST_SQUASH: begin
                // Squashed slots cannot redirect; the window freezes on stall.
                if (!stall_in) begin
                    if (r_sq_cnt == '0) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_sq_nxt = r_sq_cnt - SQ_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Reset masks the combinational outputs so nothing leaks during reset.
    assign pcsrc            = w_redirect & ~rst;
    assign flush_ifid       = w_redirect & ~rst;
    assign flush_idex       = w_redirect & ~rst;
    assign flush_exmem      = w_redirect & ~rst;
    assign redirect_pending = w_pending & ~rst;
    assign pc_target        = (w_sel_hold & ~rst) ? r_hold_tgt : mem_target;

    // Branches are counted only once, at their IDLE evaluation cycle.
    assign w_cnt_branch = (r_state == ST_IDLE) & w_resolved;
    assign w_cnt_taken  = w_cnt_branch & w_take;

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_cnt_branch),
        .q   (branch_count)
    );

    sat_counter #(.W(CNT_W)) u_taken_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_cnt_taken),
        .q   (taken_count)
    );

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl (SQUASH_CYC=3, CNT_W=3).
// Each step pushes its expected outputs; a negedge monitor pops and checks.
module tb_branch_resolve_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_valid, mem_branch, mem_zero, stall_in;
    logic [AW-1:0] mem_target;
    logic          pcsrc, flush_ifid, flush_idex, flush_exmem, redirect_pending;
    logic [AW-1:0] pc_target;
    logic [CW-1:0] branch_count, taken_count;

    typedef struct packed {
        logic          pcsrc;
        logic [AW-1:0] tgt;
        logic [2:0]    fl;
        logic          pend;
        logic [CW-1:0] bc;
        logic [CW-1:0] tc;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    compared   = 0;
    int    mismatched = 0;

    always #5 clk = ~clk;

    branch_resolve_ctrl #(.ADDR_W(AW), .SQUASH_CYC(3), .CNT_W(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .mem_valid        (mem_valid),
        .mem_branch       (mem_branch),
        .mem_zero         (mem_zero),
        .mem_target       (mem_target),
        .stall_in         (stall_in),
        .pcsrc            (pcsrc),
        .pc_target        (pc_target),
        .flush_ifid       (flush_ifid),
        .flush_idex       (flush_idex),
        .flush_exmem      (flush_exmem),
        .redirect_pending (redirect_pending),
        .branch_count     (branch_count),
        .taken_count      (taken_count)
    );

    task automatic chk(input string tag, input string fld,
                       input logic [AW-1:0] got, input logic [AW-1:0] want);
        compared++;
        assert (got === want) else begin
            mismatched++;
            $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, fld, got, want);
        end
    endtask

    // Scoreboard consumer: outputs sampled mid-cycle, away from the edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            chk(t, "pcsrc",   AW'(pcsrc), AW'(e.pcsrc));
            chk(t, "pc_tgt",  pc_target, e.tgt);
            chk(t, "flush",   AW'({flush_ifid, flush_idex, flush_exmem}), AW'(e.fl));
            chk(t, "pending", AW'(redirect_pending), AW'(e.pend));
            chk(t, "br_cnt",  AW'(branch_count), AW'(e.bc));
            chk(t, "tk_cnt",  AW'(taken_count), AW'(e.tc));
        end
    end

    // Drive one cycle of inputs and queue what the outputs must be that cycle.
    task automatic step(input string tag, input logic r, input logic v,
                        input logic b, input logic z, input logic [AW-1:0] t,
                        input logic s, input logic ep, input logic [AW-1:0] et,
                        input logic epd, input int ebc, input int etc);
        exp_t e;
        rst        = r;
        mem_valid  = v;
        mem_branch = b;
        mem_zero   = z;
        mem_target = t;
        stall_in   = s;
        e.pcsrc = ep;
        e.tgt   = et;
        e.fl    = ep ? 3'b111 : 3'b000;
        e.pend  = epd;
        e.bc    = CW'(ebc);
        e.tc    = CW'(etc);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_valid = 1'b1; mem_branch = 1'b1; mem_zero = 1'b1;
        mem_target = 32'h10; stall_in = 1'b0;
        @(posedge clk);
        #1;

        //   tag       rst v b z target  stall pcsrc tgt     pend bc tc
        step("rst1",   1, 1, 1, 1, 32'h10, 0,   0, 32'h10, 0,   0, 0);
        step("rst2",   1, 1, 1, 1, 32'h10, 0,   0, 32'h10, 0,   0, 0);
        // Not-taken then taken.
        step("ntk",    0, 1, 1, 0, 32'h20, 0,   0, 32'h20, 0,   0, 0);
        step("tk",     0, 1, 1, 1, 32'h40, 0,   1, 32'h40, 0,   1, 0);
        // Take held through the squash window; the fourth cycle redirects.
        step("sq1",    0, 1, 1, 1, 32'h50, 0,   0, 32'h50, 0,   2, 1);
        step("sq2",    0, 1, 1, 1, 32'h50, 0,   0, 32'h50, 0,   2, 1);
        step("sq3",    0, 1, 1, 1, 32'h50, 0,   0, 32'h50, 0,   2, 1);
        step("sq4tk",  0, 1, 1, 1, 32'h60, 0,   1, 32'h60, 0,   2, 1);
        step("sqb1",   0, 0, 0, 0, 32'h64, 0,   0, 32'h64, 0,   3, 2);
        step("sqb2",   0, 0, 0, 0, 32'h64, 0,   0, 32'h64, 0,   3, 2);
        step("sqb3",   0, 0, 0, 0, 32'h64, 0,   0, 32'h64, 0,   3, 2);
        // Stalled redirect: target captured, EX/MEM changes underneath.
        step("hcap",   0, 1, 1, 1, 32'h80, 1,   0, 32'h80, 0,   3, 2);
        step("hold1",  0, 1, 1, 1, 32'h99, 1,   0, 32'h80, 1,   4, 3);
        step("hold2",  0, 1, 1, 1, 32'h99, 1,   0, 32'h80, 1,   4, 3);
        step("hold3",  0, 1, 1, 1, 32'h99, 1,   0, 32'h80, 1,   4, 3);
        step("hrel",   0, 1, 1, 1, 32'h99, 0,   1, 32'h80, 1,   4, 3);
        step("hsq1",   0, 0, 0, 0, 32'hA0, 0,   0, 32'hA0, 0,   4, 3);
        step("hsq2",   0, 0, 0, 0, 32'hA0, 0,   0, 32'hA0, 0,   4, 3);
        step("hsq3",   0, 0, 0, 0, 32'hA0, 0,   0, 32'hA0, 0,   4, 3);
        // Reset during HOLD aborts the held redirect.
        step("mcap",   0, 1, 1, 1, 32'hC0, 1,   0, 32'hC0, 0,   4, 3);
        step("mhold",  0, 1, 1, 1, 32'hC4, 1,   0, 32'hC0, 1,   5, 4);
        step("mrst",   1, 1, 1, 1, 32'hC4, 1,   0, 32'hC4, 0,   5, 4);
        step("mpost1", 0, 1, 0, 1, 32'hC8, 0,   0, 32'hC8, 0,   0, 0);
        step("mpost2", 0, 1, 0, 1, 32'hC8, 0,   0, 32'hC8, 0,   0, 0);
        step("mpost3", 0, 1, 0, 1, 32'hC8, 0,   0, 32'hC8, 0,   0, 0);

        // Saturation: nine taken branches, each followed by a full squash window.
        for (int k = 0; k < 9; k++) begin
            int c0, c1;
            c0 = (k > 7) ? 7 : k;
            c1 = (k + 1 > 7) ? 7 : k + 1;
            step($sformatf("sat%0d", k), 0, 1, 1, 1, AW'(32'h100 + 4 * k), 0,
                 1, AW'(32'h100 + 4 * k), 0, c0, c0);
            for (int j = 0; j < 3; j++) begin
                step($sformatf("sat%0d_w%0d", k, j), 0, 0, 0, 0, 32'h200, 0,
                     0, 32'h200, 0, c1, c1);
            end
        end
        step("satend", 0, 0, 0, 0, 32'h204, 0, 0, 32'h204, 0, 7, 7);

        @(negedge clk);
        #1;
        chk("end", "queue_left", AW'(exp_q.size()), AW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
